// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-addressed data RAM behind a valid/ready request channel.
// Loads return RAM contents after RD_LAT cycles; stores write at the accepting
// edge and return a zero-data response. Misaligned or out-of-range requests
// return rsp_err with zero data and never touch the RAM.
//
// Optional feature macro: DMEM_BYTE_STROBE_EN
//   defined   -> stores write only the bytes whose req_be bit is set
//   undefined -> req_be is ignored and every store writes the full word
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   req_valid  request present          req_ready  request accepted this cycle
//   req_we     1 = store, 0 = load      req_addr   byte address
//   req_wdata  store data               req_be     byte strobes
//   rsp_valid  one-cycle response pulse rsp_rdata  load data (0 for store/error)
//   rsp_err    misaligned/out of range  txn_count  accepted requests, wraps
module data_mem_ctrl #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [31:0]           txn_count
);

    localparam int unsigned BYTES     = DATA_W / 8;
    localparam int unsigned LSB       = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned WAIT_INIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] pend_rdata_q, pend_rdata_d;
    logic              pend_err_q, pend_err_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       txn_q, txn_d;

    logic [ADDR_W-1:0] off_c;
    logic [ADDR_W-1:0] word_c;
    logic [IDX_W-1:0]  idx_c;
    logic              addr_err_c;
    logic [DATA_W-1:0] rd_now_c;
    logic              accept_c;

    // Address decode and the load data as seen at the accepting edge
    always_comb begin
        off_c      = req_addr - ADDR_W'(BASE_ADDR);
        word_c     = off_c >> LSB;
        idx_c      = word_c[IDX_W-1:0];
        addr_err_c = ((req_addr & ADDR_W'(BYTES - 1)) != '0)
                  || (req_addr < ADDR_W'(BASE_ADDR))
                  || (word_c >= ADDR_W'(DEPTH));
        rd_now_c   = (req_we || addr_err_c) ? '0 : mem[idx_c];
        accept_c   = req_valid && req_ready_q;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_rdata_d = pend_rdata_q;
        pend_err_d   = pend_err_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = '0;
        rsp_err_d    = 1'b0;
        txn_d        = txn_q;

        if (accept_c) begin
            txn_d = txn_q + 32'd1;
        end

        case (state_q)
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                if (accept_c) begin
                    if (RD_LAT == 1) begin
                        // Single-cycle latency: respond straight from the decode
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = rd_now_c;
                        rsp_err_d   = addr_err_c;
                    end else begin
                        state_d      = S_WAIT;
                        cnt_d        = CNT_W'(WAIT_INIT);
                        pend_rdata_d = rd_now_c;
                        pend_err_d   = addr_err_c;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pend_rdata_q;
                    rsp_err_d   = pend_err_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d != S_WAIT);
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pend_rdata_q <= '0;
            pend_err_q   <= 1'b0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            txn_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_rdata_q <= pend_rdata_d;
            pend_err_q   <= pend_err_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            txn_q        <= txn_d;
        end
    end

    // RAM write port; contents are deliberately not reset
`ifdef DMEM_BYTE_STROBE_EN
    always_ff @(posedge clk) begin
        if (accept_c && req_we && !addr_err_c) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (req_be[b]) begin
                    mem[idx_c][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end
`else
    logic unused_be_c;
    assign unused_be_c = ^req_be;

    always_ff @(posedge clk) begin
        if (accept_c && req_we && !addr_err_c) begin
            mem[idx_c] <= req_wdata;
        end
    end
`endif

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign txn_count = txn_q;

endmodule
